// File: rtl/rc_pwm_capture.sv
// NCH-channel RC PWM width decoder: update/value appear 2 edges after a fall is first sampled; no backpressure.
// Loss detection per channel; define RCPWM_FAILSAFE_EN to force FAILSAFE onto value while a channel is lost.
module rc_pwm_capture #(
  parameter int NCH          = 4,
  parameter int TICKS_PER_US = 50,
  parameter int MIN_US       = 1000,
  parameter int SPAN         = 1000,
  parameter int ACC_LO_US    = 800,
  parameter int ACC_HI_US    = 2200,
  parameter int TIMEOUT_CYC  = 2500000,
  parameter int OUT_W        = 11,
  parameter int FAILSAFE     = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       pwm_in,
  output logic [NCH*OUT_W-1:0] value,
  output logic [NCH-1:0]       update,
  output logic [NCH-1:0]       valid,
  output logic [NCH-1:0]       lost
);

  localparam int PW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam int UW = $clog2(ACC_HI_US + 2);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [PW-1:0]    PRE_MAX = PW'(TICKS_PER_US - 1);
  localparam logic [UW-1:0]    US_SAT  = UW'(ACC_HI_US + 1);
  localparam logic [UW-1:0]    US_LO   = UW'(ACC_LO_US);
  localparam logic [UW-1:0]    US_HI   = UW'(ACC_HI_US);
  localparam logic [TW-1:0]    TO_MAX  = TW'(TIMEOUT_CYC);
  localparam logic [OUT_W-1:0] FS_VAL  = OUT_W'(FAILSAFE);

`ifdef RCPWM_FAILSAFE_EN
  localparam logic FS_EN = 1'b1;
`else
  localparam logic FS_EN = 1'b0;
`endif

  localparam logic [OUT_W-1:0] RST_VAL = FS_EN ? FS_VAL : '0;

  typedef enum logic [1:0] {WAIT_LOW, IDLE, HIGH} state_t;

  logic [NCH-1:0] s1_q, s2_q, s2d_q;
  logic [NCH-1:0] rise, fall;

  state_t           state_q [NCH];
  state_t           state_d [NCH];
  logic [PW-1:0]    pre_q   [NCH];
  logic [PW-1:0]    pre_d   [NCH];
  logic [UW-1:0]    us_q    [NCH];
  logic [UW-1:0]    us_d    [NCH];
  logic [TW-1:0]    to_q    [NCH];
  logic [TW-1:0]    to_d    [NCH];
  logic [OUT_W-1:0] val_q   [NCH];
  logic [OUT_W-1:0] val_d   [NCH];
  logic [NCH-1:0]   update_q, update_d;
  logic [NCH-1:0]   valid_q, valid_d;
  logic [NCH-1:0]   lost_q, lost_d;

  // Synchroniser is deliberately left out of reset so a pulse high across reset stays visible as high.
  always_ff @(posedge clk) begin
    s1_q  <= pwm_in;
    s2_q  <= s1_q;
    s2d_q <= s2_q;
  end

  assign rise = s2_q & ~s2d_q;
  assign fall = ~s2_q & s2d_q;

  always_comb begin
    logic            acc;
    logic [PW-1:0]   pre_nxt;
    logic [UW-1:0]   us_nxt;
    logic [TW-1:0]   to_nxt;
    int              diff;
    for (int i = 0; i < NCH; i++) begin
      acc     = 1'b0;
      pre_nxt = (pre_q[i] == PRE_MAX) ? '0 : pre_q[i] + 1'b1;
      us_nxt  = us_q[i];
      if (pre_q[i] == PRE_MAX && us_q[i] != US_SAT) begin
        us_nxt = us_q[i] + 1'b1;
      end
      to_nxt = (to_q[i] == TO_MAX) ? TO_MAX : to_q[i] + 1'b1;
      diff   = int'(us_nxt) - MIN_US;

      state_d[i]  = state_q[i];
      pre_d[i]    = pre_q[i];
      us_d[i]     = us_q[i];
      to_d[i]     = to_nxt;
      val_d[i]    = val_q[i];
      update_d[i] = 1'b0;
      valid_d[i]  = valid_q[i];
      lost_d[i]   = lost_q[i];

      case (state_q[i])
        WAIT_LOW: begin
          if (!s2_q[i]) state_d[i] = IDLE;
        end
        IDLE: begin
          if (rise[i]) begin
            pre_d[i]   = '0;
            us_d[i]    = '0;
            state_d[i] = HIGH;
          end
        end
        HIGH: begin
          // Every HIGH cycle counts, including the one that sees the fall, so the width is floor(H/TICKS).
          pre_d[i] = pre_nxt;
          us_d[i]  = us_nxt;
          if (fall[i]) begin
            state_d[i] = IDLE;
            acc        = (us_nxt >= US_LO) && (us_nxt <= US_HI);
          end else if (us_nxt > US_HI) begin
            state_d[i] = WAIT_LOW;
          end
        end
        default: state_d[i] = WAIT_LOW;
      endcase

      if (acc) begin
        if (diff < 0)          val_d[i] = '0;
        else if (diff > SPAN)  val_d[i] = OUT_W'(SPAN);
        else                   val_d[i] = OUT_W'(diff);
        update_d[i] = 1'b1;
        valid_d[i]  = 1'b1;
        lost_d[i]   = 1'b0;
        to_d[i]     = '0;
      end else if (to_nxt == TO_MAX && !lost_q[i]) begin
        lost_d[i]  = 1'b1;
        valid_d[i] = 1'b0;
        if (FS_EN) val_d[i] = FS_VAL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= WAIT_LOW;
        pre_q[i]   <= '0;
        us_q[i]    <= '0;
        to_q[i]    <= '0;
        val_q[i]   <= RST_VAL;
      end
      update_q <= '0;
      valid_q  <= '0;
      lost_q   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        pre_q[i]   <= pre_d[i];
        us_q[i]    <= us_d[i];
        to_q[i]    <= to_d[i];
        val_q[i]   <= val_d[i];
      end
      update_q <= update_d;
      valid_q  <= valid_d;
      lost_q   <= lost_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign value[g*OUT_W +: OUT_W] = val_q[g];
  end

  assign update = update_q;
  assign valid  = valid_q;
  assign lost   = lost_q;

endmodule

// File: tb/tb_rc_pwm_capture.sv
// Bench for rc_pwm_capture: directed and random pulses against an event-level model of widths, resets and timeouts.
module tb_rc_pwm_capture;

  localparam int NCH    = 4;
  localparam int TICKS  = 2;
  localparam int MIN_US = 1000;
  localparam int SPAN   = 1000;
  localparam int ACC_LO = 800;
  localparam int ACC_HI = 2200;
  localparam int TMO    = 8000;
  localparam int OUT_W  = 11;
  localparam int FS     = 37;

`ifdef RCPWM_FAILSAFE_EN
  localparam bit FS_ON = 1'b1;
`else
  localparam bit FS_ON = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NCH-1:0]       pwm_in = '0;
  logic [NCH*OUT_W-1:0] value;
  logic [NCH-1:0]       update;
  logic [NCH-1:0]       valid;
  logic [NCH-1:0]       lost;

  rc_pwm_capture #(
    .NCH(NCH), .TICKS_PER_US(TICKS), .MIN_US(MIN_US), .SPAN(SPAN),
    .ACC_LO_US(ACC_LO), .ACC_HI_US(ACC_HI), .TIMEOUT_CYC(TMO),
    .OUT_W(OUT_W), .FAILSAFE(FS)
  ) dut (
    .clk(clk), .reset(reset), .pwm_in(pwm_in),
    .value(value), .update(update), .valid(valid), .lost(lost)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rst = 0;
  bit prev      [NCH];
  int run_start [NCH];
  int pend_cyc  [NCH];
  int pend_r    [NCH];
  int pend_val  [NCH];
  int last_evt  [NCH];
  bit acc_flag  [NCH];
  int last_val  [NCH];
  bit exp_upd   [NCH];
  int p_start   [NCH];
  int p_len     [NCH];

  task automatic chk(input string tag, input int ch, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s ch%0d cycle %0d: observed %0d expected %0d", tag, ch, cyc, obs, expv);
    end
  endtask

  function automatic int exp_value(input int i, input bit lx);
    if (FS_ON && (lx || !acc_flag[i])) return FS;
    if (acc_flag[i]) return last_val[i];
    return 0;
  endfunction

  // One clock edge: fold this edge's samples into the model, then compare all outputs.
  task automatic tick();
    bit s, lx;
    int h, w, v;
    @(posedge clk);
    cyc++;
    if (reset) last_rst = cyc;
    for (int i = 0; i < NCH; i++) begin
      s = pwm_in[i];
      exp_upd[i] = 1'b0;
      if (reset) begin
        acc_flag[i] = 1'b0;
        last_evt[i] = cyc;
      end
      if (s && !prev[i]) run_start[i] = cyc;
      if (!s && prev[i]) begin
        h = cyc - run_start[i];
        w = h / TICKS;
        if (w >= ACC_LO && w <= ACC_HI) begin
          v = w - MIN_US;
          if (v < 0) v = 0;
          if (v > SPAN) v = SPAN;
          pend_cyc[i] = cyc + 2;
          pend_r[i]   = run_start[i];
          pend_val[i] = v;
        end
      end
      prev[i] = s;
      // A pulse counts only if no reset edge fell between one edge after its rise and its publish edge.
      if (pend_cyc[i] == cyc && last_rst < pend_r[i] + 1) begin
        exp_upd[i]  = 1'b1;
        acc_flag[i] = 1'b1;
        last_val[i] = pend_val[i];
        last_evt[i] = cyc;
      end
    end
    #1;
    if (last_rst > 0) begin
      for (int i = 0; i < NCH; i++) begin
        lx = (cyc - last_evt[i]) >= TMO;
        chk("update", i, 32'(update[i]), 32'(exp_upd[i]));
        chk("lost",   i, 32'(lost[i]),   32'(lx));
        chk("valid",  i, 32'(valid[i]),  32'(acc_flag[i] && !lx));
        chk("value",  i, 32'(value[i*OUT_W +: OUT_W]), exp_value(i, lx));
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse(input int ch, input int hcyc);
    pwm_in[ch] = 1'b1;
    idle(hcyc);
    pwm_in[ch] = 1'b0;
    idle(5);
  endtask

  task automatic multi(input int total);
    for (int c = 0; c < total; c++) begin
      for (int i = 0; i < NCH; i++) pwm_in[i] = (c >= p_start[i]) && (c < p_start[i] + p_len[i]);
      tick();
    end
    pwm_in = '0;
    idle(5);
  endtask

  initial begin
    int total, e;
    for (int i = 0; i < NCH; i++) begin
      prev[i] = 1'b0; run_start[i] = 0; pend_cyc[i] = -10; pend_r[i] = 0; pend_val[i] = 0;
      last_evt[i] = 0; acc_flag[i] = 1'b0; last_val[i] = 0; exp_upd[i] = 1'b0;
    end

    reset = 1'b1;
    idle(5);
    reset = 1'b0;
    idle(3);
    chk("rst_value0", 0, 32'(value[0 +: OUT_W]), FS_ON ? FS : 0);

    pulse(0, 1500 * TICKS);
    chk("tp_1500", 0, 32'(value[0 +: OUT_W]), 500);
    pulse(0, 900 * TICKS);
    chk("tp_900", 0, 32'(value[0 +: OUT_W]), 0);
    pulse(0, 2100 * TICKS);
    chk("tp_2100", 0, 32'(value[0 +: OUT_W]), 1000);

    pulse(0, 1500 * TICKS);
    pulse(0, 500 * TICKS);
    pulse(0, 3000 * TICKS);
    chk("after_rejects", 0, 32'(value[0 +: OUT_W]), 500);
    idle(1500);
    chk("loss_lost", 0, 32'(lost[0]), 1);
    chk("loss_value", 0, 32'(value[0 +: OUT_W]), FS_ON ? FS : 500);
    pulse(0, 1200 * TICKS);
    chk("recover_1200", 0, 32'(value[0 +: OUT_W]), 200);
    chk("recover_lost", 0, 32'(lost[0]), 0);

    pwm_in[0] = 1'b1;
    idle(800 * TICKS);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle(700 * TICKS - 1);
    pwm_in[0] = 1'b0;
    idle(5);
    chk("midrst_valid", 0, 32'(valid[0]), 0);
    chk("midrst_value", 0, 32'(value[0 +: OUT_W]), FS_ON ? FS : 0);
    pulse(0, 1500 * TICKS);
    chk("post_rst_1500", 0, 32'(value[0 +: OUT_W]), 500);

    p_start[0] = 1000; p_len[0] = 1000 * TICKS;
    p_start[1] = 500;  p_len[1] = 1250 * TICKS;
    p_start[2] = 0;    p_len[2] = 1750 * TICKS;
    p_start[3] = 0;    p_len[3] = 2000 * TICKS;
    multi(4010);
    chk("quad0", 0, 32'(value[0*OUT_W +: OUT_W]), 0);
    chk("quad1", 1, 32'(value[1*OUT_W +: OUT_W]), 250);
    chk("quad2", 2, 32'(value[2*OUT_W +: OUT_W]), 750);
    chk("quad3", 3, 32'(value[3*OUT_W +: OUT_W]), 1000);

    pulse(1, 799 * TICKS + 1);
    chk("lo_reject", 1, 32'(value[1*OUT_W +: OUT_W]), 250);
    pulse(1, 800 * TICKS);
    chk("lo_accept", 1, 32'(value[1*OUT_W +: OUT_W]), 0);
    pulse(1, 2200 * TICKS + 1);
    chk("hi_accept", 1, 32'(value[1*OUT_W +: OUT_W]), 1000);
    pulse(1, 2201 * TICKS);
    pulse(1, 999 * TICKS + 1);
    chk("below_min", 1, 32'(value[1*OUT_W +: OUT_W]), 0);

    for (int r = 0; r < 5; r++) begin
      total = 0;
      for (int i = 0; i < NCH; i++) begin
        p_start[i] = int'($urandom_range(0, 200));
        p_len[i]   = int'($urandom_range(700, 2300)) * TICKS + int'($urandom_range(0, TICKS - 1));
        e = p_start[i] + p_len[i];
        if (e > total) total = e;
      end
      multi(total + 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rc_pwm_capture.md
# rc_pwm_capture

Multi-channel RC receiver pulse-width decoder. It replaces the single-channel Crius PWM reader with NCH independent channels and microsecond-accurate width measurement. Each accepted pulse is range-checked, offset-corrected, clamped and published with a one-cycle update strobe. Per-channel signal-loss detection feeds the flight controller's failsafe logic.

## Interface
- NCH, 4, number of PWM channels
- TICKS_PER_US, 50, clk cycles per microsecond (50 MHz)
- MIN_US, 1000, pulse width mapped to output 0
- SPAN, 1000, output full scale; output = clamp(width_us − MIN_US, 0, SPAN)
- ACC_LO_US, 800, shortest accepted pulse
- ACC_HI_US, 2200, longest accepted pulse
- TIMEOUT_CYC, 2500000, cycles without an accepted pulse before loss (50 ms)
- OUT_W, 11, output width per channel; must hold SPAN
- FAILSAFE, 0, value driven on loss (only with RCPWM_FAILSAFE_EN)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pwm_in  in  NCH  asynchronous receiver pulses
- value  out  NCH*OUT_W  channel i at bits [i*OUT_W +: OUT_W]
- update  out  NCH  one-cycle strobe when value[i] is written
- valid  out  NCH  at least one pulse accepted and channel not lost
- lost  out  NCH  no accepted pulse for TIMEOUT_CYC cycles

## Operation
- Each pwm_in bit passes through a 2-flop synchroniser (s1, s2) into s2_d for edge detection. rise = s2 & ~s2_d; fall = ~s2 & s2_d.
- Per-channel FSM states:
  - WAIT_LOW: entered on reset. Go to IDLE when s2 = 0. A pulse already high at reset is never measured.
  - IDLE: on rise, clear the prescaler and us_cnt, then go to HIGH.
  - HIGH: the prescaler counts 0..TICKS_PER_US−1. On wrap, us_cnt increments, saturating at ACC_HI_US+1.
    - On fall with ACC_LO_US ≤ us_cnt ≤ ACC_HI_US: accept and go to IDLE.
    - On fall otherwise: reject silently and go to IDLE.
    - If us_cnt exceeds ACC_HI_US while high: go to WAIT_LOW (reject).
- width_us = floor(synchronised high cycles / TICKS_PER_US).
- Accept actions:
  - value ← clamp(us_cnt − MIN_US, 0, SPAN), computed signed with no wrap.
  - update pulses; valid ← 1; lost ← 0; the timeout counter clears.
- Timeout counter: counts every cycle and saturates at TIMEOUT_CYC. On reaching it: lost ← 1, valid ← 0.
- If an accept and timeout expiry occur in the same cycle, the accept wins (lost stays 0).
- Rejected pulses affect no output and do not clear the timeout.
- Channels are fully independent; simultaneous edges on any channels are each handled the same cycle.

## Timing
- Reset values:
  - value = 0 (FAILSAFE with RCPWM_FAILSAFE_EN)
  - update = 0, valid = 0, lost = 0
  - all FSMs in WAIT_LOW; counters cleared
- Latency: if pwm_in is first sampled low at clk edge N, update and the new value appear after edge N+2 and stay for exactly one cycle (update).
- Measurement uncertainty: ±1 clk cycle per edge from synchronisation.
- lost asserts exactly TIMEOUT_CYC cycles after the cycle update pulsed (or after reset).
- Reset asserted mid-pulse: the partial pulse is discarded and all outputs return to reset values on the next edge.

## Configuration
- RCPWM_FAILSAFE_EN defined: on lost assertion, value ← FAILSAFE in the same cycle, and reset value = FAILSAFE. The next accept overwrites it.
- Not defined: value holds the last accepted measurement through loss; only valid/lost indicate the condition.

## Test plan
- ch0 high 75000 cycles (1500 µs) → after fall+3 edges: value[0] = 500, update[0] one cycle, valid[0] = 1; other channels unchanged.
- Widths 900 µs and 2100 µs → value 0 and 1000 respectively (clamping), each with update.
- 500 µs glitch, then 3000 µs pulse → no update; value stays 500; the timeout counter is not cleared.
- One accepted pulse, then pwm_in held low → lost = 1 and valid = 0 exactly 2500000 cycles after update; value = FAILSAFE with the macro, 500 without. A next 1200 µs pulse → value 200, lost = 0.
- Reset asserted 40000 cycles into a 1500 µs pulse → outputs at reset values; no update for that pulse; the following 1500 µs pulse yields 500.
- Four channels at 1000/1250/1750/2000 µs with overlapping, coincident falls → values 0/250/750/1000, independent updates in the correct cycles.
